adder_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one n-bit adder datapath among NREQ requesters.
- Accepts one add request at a time and captures its operands.
- Drives the adder for one cycle, then holds the registered sum, carry and requester ID until the consumer accepts them.
- Sits between the requesting units and the single adder instance.

---
 rtl/adder_arbiter_pkg.sv | 13 +
 rtl/adder_arbiter_if.sv | 29 ++
 rtl/adder.sv | 12 +
 rtl/adder_arbiter_rr_picker.sv | 29 ++
 rtl/adder_arbiter.sv | 117 +++++++++++
 tb/tb_adder_arbiter.sv | 193 +++++++++++++++++++
 6 files changed

// File: rtl/adder_arbiter_pkg.sv
// Shared types and default widths for the round-robin adder arbiter.
package adder_arb_pkg;

    localparam int unsigned N_DEF    = 32;
    localparam int unsigned NREQ_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester/consumer bus of the adder arbiter; the arbiter sits on the slave side.
interface adder_arbiter_if
    import adder_arb_pkg::*;
#(
    parameter int unsigned N    = N_DEF,
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] a;
    logic [NREQ*N-1:0] b;
    logic [NREQ-1:0]   gnt_c;
    logic              busy;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [N-1:0]      sum;
    logic              c_out;

    modport master (
        output req, a, b, resp_ready,
        input  gnt_c, busy, resp_valid, resp_id, sum, c_out
    );

    modport slave (
        input  req, a, b, resp_ready,
        output gnt_c, busy, resp_valid, resp_id, sum, c_out
    );
endinterface

// File: rtl/adder.sv
// Shared n-bit adder datapath with full carry-out; output forced to 0 when idle.
module adder #(
    parameter int unsigned N = 32
) (
    input  logic         en_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);
    assign {cout_o, sum_o} = en_i ? ((N+1)'(a_i) + (N+1)'(b_i)) : '0;
endmodule

// File: rtl/adder_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module rr_picker #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);
    int unsigned j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = 32'(ptr_i) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!any_o && req_i[IDW'(j)]) begin
                any_o             = 1'b1;
                idx_o             = IDW'(j);
                gnt_o[IDW'(j)]    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter/sequencer sharing one adder among NREQ requesters:
// grant+capture, one execute cycle, then hold the result until accepted.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned N    = N_DEF,
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic           clk,
    input  logic           rst_n,
    adder_arbiter_if.slave bus
);
    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [IDW-1:0]  resp_id_q, resp_id_d;
    logic [N-1:0]    a_q, a_d, b_q, b_d;
    logic [N-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            busy_q, valid_q;
    logic [NREQ-1:0] gnt_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic            add_en;
    logic [N-1:0]    add_sum;
    logic            add_cout;

    rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_picker (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    adder #(.N(N)) u_adder (
        .en_i   (add_en),
        .a_i    (a_q),
        .b_i    (b_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // Next-state, capture and Mealy grant
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        resp_id_d = resp_id_q;
        add_en    = 1'b0;
        gnt_d     = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_gnt;
                    a_d     = bus.a[N*32'(pick_idx) +: N];
                    b_d     = bus.b[N*32'(pick_idx) +: N];
                    id_d    = pick_idx;
                    ptr_d   = (pick_idx == IDW'(NREQ-1)) ? '0 : pick_idx + IDW'(1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                add_en    = 1'b1;
                sum_d     = add_sum;
                cout_d    = add_cout;
                resp_id_d = id_q;
                state_d   = RESP;
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            resp_id_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            resp_id_q <= resp_id_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            busy_q    <= (state_d != IDLE);
            valid_q   <= (state_d == RESP);
        end
    end

    // Grant is combinational, so it must be forced low while reset is asserted
    assign bus.gnt_c      = rst_n ? gnt_d : '0;
    assign bus.busy       = busy_q;
    assign bus.resp_valid = valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.sum        = sum_q;
    assign bus.c_out      = cout_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter (NREQ=4, n=32).
module tb_adder_arbiter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    adder_arbiter_if #(.N(32), .NREQ(4), .IDW(2)) bus ();

    adder_arbiter #(.N(32), .NREQ(4), .IDW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.req = '0;
        bus.a = '0;
        bus.b = '0;
        bus.resp_ready = 1'b0;

        // Reset state, including grant suppressed while requests are present
        step(); step();
        bus.req = 4'b1111;
        #1;
        check("rst_gnt",   64'(bus.gnt_c), 64'h0);
        check("rst_busy",  64'(bus.busy), 64'h0);
        check("rst_valid", 64'(bus.resp_valid), 64'h0);
        check("rst_id",    64'(bus.resp_id), 64'h0);
        check("rst_out",   64'(bus.sum), 64'h0);
        check("rst_cout",  64'(bus.c_out), 64'h0);

        // Single uncontended op from requester 2, with carry
        step();
        rst_n = 1'b1;
        bus.req = 4'b0100;
        bus.a[64 +: 32] = 32'h01B30FFF;
        bus.b[64 +: 32] = 32'hFFA5FFFF;
        #1;
        check("t1_gnt", 64'(bus.gnt_c), 64'h4);
        step();
        bus.req = '0;
        #1;
        check("t1_exec_gnt",   64'(bus.gnt_c), 64'h0);
        check("t1_exec_busy",  64'(bus.busy), 64'h1);
        check("t1_exec_valid", 64'(bus.resp_valid), 64'h0);
        step(); #1;
        check("t1_valid", 64'(bus.resp_valid), 64'h1);
        check("t1_out",   64'(bus.sum), 64'h01590FFE);
        check("t1_cout",  64'(bus.c_out), 64'h1);
        check("t1_id",    64'(bus.resp_id), 64'h2);
        step(); #1;
        check("t1_hold_valid", 64'(bus.resp_valid), 64'h1);
        step();
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        #1;
        check("t1_done_valid", 64'(bus.resp_valid), 64'h0);
        check("t1_done_busy",  64'(bus.busy), 64'h0);
        check("t1_done_out",   64'(bus.sum), 64'h01590FFE);

        // No-carry op from requester 0 (pointer is 3, wraps to 0)
        step();
        bus.req = 4'b0001;
        bus.a[0 +: 32] = 32'd5;
        bus.b[0 +: 32] = 32'd7;
        #1;
        check("t2_gnt", 64'(bus.gnt_c), 64'h1);
        step();
        bus.req = '0;
        step(); #1;
        check("t2_out",  64'(bus.sum), 64'h0000000C);
        check("t2_cout", 64'(bus.c_out), 64'h0);
        check("t2_id",   64'(bus.resp_id), 64'h0);
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;

        // Reset pulse in IDLE returns pointer to 0
        step();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.a[i*32 +: 32] = 32'hF0000000 + 32'(i);
            bus.b[i*32 +: 32] = 32'h20000000 + 32'(i);
        end
        step();
        rst_n = 1'b1;
        bus.req = 4'b1111;
        bus.resp_ready = 1'b1;
        #1;

        // Fairness: all requesting, grants 0,1,2,3,0 every 3 cycles
        for (int k = 0; k < 5; k++) begin
            check($sformatf("fair%0d_gnt", k), 64'(bus.gnt_c), 64'(4'b0001 << (k % 4)));
            step(); #1;
            check($sformatf("fair%0d_exec_gnt", k), 64'(bus.gnt_c), 64'h0);
            step();
            if (k == 4) bus.resp_ready = 1'b0;
            #1;
            check($sformatf("fair%0d_valid", k), 64'(bus.resp_valid), 64'h1);
            check($sformatf("fair%0d_id", k),    64'(bus.resp_id), 64'(k % 4));
            check($sformatf("fair%0d_out", k),   64'(bus.sum), 64'(32'h10000000 + 32'(2 * (k % 4))));
            check($sformatf("fair%0d_cout", k),  64'(bus.c_out), 64'h1);
            check($sformatf("fair%0d_resp_gnt", k), 64'(bus.gnt_c), 64'h0);
            if (k < 4) begin
                step(); #1;
            end
        end

        // Backpressure: stay in RESP with stable result and no grants
        for (int c = 0; c < 5; c++) begin
            step(); #1;
            check($sformatf("bp%0d_valid", c), 64'(bus.resp_valid), 64'h1);
            check($sformatf("bp%0d_out", c),   64'(bus.sum), 64'h10000000);
            check($sformatf("bp%0d_id", c),    64'(bus.resp_id), 64'h0);
            check($sformatf("bp%0d_gnt", c),   64'(bus.gnt_c), 64'h0);
        end
        step();
        bus.resp_ready = 1'b1;
        #1;
        check("bp_ready_gnt", 64'(bus.gnt_c), 64'h0);
        step(); #1;
        check("bp_next_gnt",   64'(bus.gnt_c), 64'h2);
        check("bp_next_valid", 64'(bus.resp_valid), 64'h0);
        check("bp_next_out",   64'(bus.sum), 64'h10000000);

        // Reset during EXEC aborts the op; pointer returns to 0
        step();
        rst_n = 1'b0;
        #1;
        check("rx_gnt",   64'(bus.gnt_c), 64'h0);
        check("rx_busy",  64'(bus.busy), 64'h0);
        check("rx_valid", 64'(bus.resp_valid), 64'h0);
        check("rx_id",    64'(bus.resp_id), 64'h0);
        check("rx_out",   64'(bus.sum), 64'h0);
        check("rx_cout",  64'(bus.c_out), 64'h0);
        step();
        rst_n = 1'b1;
        #1;
        check("rx_rel_gnt", 64'(bus.gnt_c), 64'h1);

        // Withdrawn request from requester 1 during RESP leaves pointer at 1
        step();
        bus.req = '0;
        #1;
        check("wd_exec_busy", 64'(bus.busy), 64'h1);
        step();
        bus.req = 4'b0010;
        bus.resp_ready = 1'b0;
        #1;
        check("wd_resp_valid", 64'(bus.resp_valid), 64'h1);
        check("wd_resp_gnt",   64'(bus.gnt_c), 64'h0);
        check("wd_resp_out",   64'(bus.sum), 64'h10000000);
        check("wd_resp_cout",  64'(bus.c_out), 64'h1);
        step();
        bus.req = '0;
        bus.resp_ready = 1'b1;
        #1;
        check("wd_drop_gnt", 64'(bus.gnt_c), 64'h0);
        step(); #1;
        check("wd_idle_gnt",  64'(bus.gnt_c), 64'h0);
        check("wd_idle_busy", 64'(bus.busy), 64'h0);
        step();
        bus.req = 4'b1111;
        #1;
        check("wd_ptr_gnt", 64'(bus.gnt_c), 64'h2);
        step();
        bus.req = '0;
        step(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
